seq_div: RTL and testbench

- Sequential signed (two's-complement) divider; the inverse operation of the team's sequential multiplier.
- Divides a 2*WIDTH-bit dividend by a WIDTH-bit divisor using a restoring shift-subtract on magnitudes, producing one quotient bit per clock.
- Recovers operands from multiplier products and provides quotient/remainder to datapath blocks that do not need single-cycle division.

---
 rtl/seq_div_if.sv | 26 ++
 rtl/seq_div.sv | 120 ++++++++++++
 tb/tb_seq_div.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_div_if.sv
// seq_div_if: handshake and data bundle for the sequential signed divider.
//   master : drives start, n (dividend), d (divisor); observes results
//   slave  : the divider; drives q, r, rdy, busy, dz, ovf
interface seq_div_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic [2*WIDTH-1:0]   n;
  logic [WIDTH-1:0]     d;
  logic [2*WIDTH-1:0]   q;
  logic [WIDTH-1:0]     r;
  logic                 rdy;
  logic                 busy;
  logic                 dz;
  logic                 ovf;

  modport master (
    output start, n, d,
    input  q, r, rdy, busy, dz, ovf
  );

  modport slave (
    input  start, n, d,
    output q, r, rdy, busy, dz, ovf
  );
endinterface

// File: rtl/seq_div.sv
// seq_div: sequential signed divider, 2*WIDTH-bit dividend by WIDTH-bit divisor.
// Restoring shift-subtract on magnitudes, one quotient bit per clock, signs
// applied in a final fix-up cycle.
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : seq_div_if slave (start/n/d in; q/r/rdy/busy/dz/ovf out)
//
// state | meaning
// IDLE  | waiting for start, outputs reset values
// RUN   | shifting/subtracting, one quotient bit per edge
// FIX   | apply signs, flag overflow/divide-by-zero, raise rdy
// DONE  | result held until the next accepted start
module seq_div #(
  parameter int WIDTH    = 8,
  parameter int CTRWIDTH = 5
) (
  input  logic      clk,
  input  logic      reset,
  seq_div_if.slave  bus
);
  localparam int NW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t                state;
  logic                  sign_n;
  logic                  sign_d;
  logic [NW-1:0]         dvd;      // dividend magnitude, becomes quotient magnitude
  logic [WIDTH-1:0]      dmag;
  logic [WIDTH:0]        rem;      // partial remainder
  logic [CTRWIDTH-1:0]   ctr;
  logic                  dz_pend;

  logic [WIDTH+1:0]      rem_sh;
  logic [WIDTH+1:0]      trial;
  logic [NW-1:0]         n_abs;
  logic [WIDTH-1:0]      d_abs;

  always_comb begin
    rem_sh = {rem, dvd[NW-1]};
    // Top bit of trial is the borrow: set when the shifted remainder < |d|.
    trial  = rem_sh - {2'b00, dmag};
    n_abs  = bus.n[NW-1] ? -bus.n : bus.n;
    d_abs  = bus.d[WIDTH-1] ? -bus.d : bus.d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      sign_n   <= 1'b0;
      sign_d   <= 1'b0;
      dvd      <= '0;
      dmag     <= '0;
      rem      <= '0;
      ctr      <= '0;
      dz_pend  <= 1'b0;
      bus.q    <= '0;
      bus.r    <= '0;
      bus.rdy  <= 1'b0;
      bus.busy <= 1'b0;
      bus.dz   <= 1'b0;
      bus.ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            sign_n   <= bus.n[NW-1];
            sign_d   <= bus.d[WIDTH-1];
            dvd      <= n_abs;
            dmag     <= d_abs;
            rem      <= '0;
            ctr      <= '0;
            dz_pend  <= (bus.d == '0);
            bus.rdy  <= 1'b0;
            bus.busy <= 1'b1;
            bus.dz   <= 1'b0;
            bus.ovf  <= 1'b0;
            state    <= (bus.d == '0) ? FIX : RUN;
          end
        end

        RUN: begin
          if (trial[WIDTH+1]) begin
            rem <= rem_sh[WIDTH:0];
            dvd <= {dvd[NW-2:0], 1'b0};
          end else begin
            rem <= trial[WIDTH:0];
            dvd <= {dvd[NW-2:0], 1'b1};
          end
          ctr <= ctr + 1'b1;
          if (ctr == CTRWIDTH'(NW - 1))
            state <= FIX;
        end

        FIX: begin
          if (dz_pend && ctr == '0) begin
            // Divide-by-zero result is released on the second edge after accept.
            ctr <= ctr + 1'b1;
          end else begin
            if (dz_pend) begin
              bus.q  <= '0;
              bus.r  <= '0;
              bus.dz <= 1'b1;
            end else begin
              bus.q   <= (sign_n ^ sign_d) ? -dvd : dvd;
              bus.r   <= sign_n ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
              // Only -2^(NW-1) / -1 produces an unrepresentable positive quotient.
              bus.ovf <= (dvd == {1'b1, {(NW-1){1'b0}}}) && (sign_n == sign_d);
            end
            bus.rdy  <= 1'b1;
            bus.busy <= 1'b0;
            state    <= DONE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_div.sv
module tb_seq_div;
  localparam int W  = 8;
  localparam int NW = 2 * W;
  localparam int LAT    = NW + 1;
  localparam int LAT_DZ = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  seq_div_if #(.WIDTH(W)) bus ();

  seq_div #(.WIDTH(W), .CTRWIDTH(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: plain integer division (truncates toward zero, remainder
  // takes the dividend's sign). Packed as {q, r, dz, ovf}.
  function automatic logic [NW+W+1:0] model(input logic [NW-1:0] nn, input logic [W-1:0] dd);
    longint ni, di, qi, ri, lim;
    logic [63:0] qb, rb;
    logic ov;
    ni = longint'($signed(nn));
    di = longint'($signed(dd));
    if (di == 0) return {{NW{1'b0}}, {W{1'b0}}, 1'b1, 1'b0};
    qi  = ni / di;
    ri  = ni % di;
    qb  = qi;
    rb  = ri;
    lim = 1;
    lim = lim << (NW - 1);
    ov  = (qi >= lim);
    return {qb[NW-1:0], rb[W-1:0], 1'b0, ov};
  endfunction

  // Accept one operation and wait for rdy; lat counts edges after the accepting edge.
  task automatic run_op(input logic [NW-1:0] nn, input logic [W-1:0] dd,
                        output int lat, output bit busy_ok);
    @(negedge clk);
    bus.start = 1'b1; bus.n = nn; bus.d = dd;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0; busy_ok = 1'b1;
    while (!bus.rdy && lat < 40) begin
      if (!bus.busy) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (bus.busy) busy_ok = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({bus.q, bus.r, bus.rdy, bus.busy, bus.dz, bus.ovf} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got q=%h r=%h rdy=%b busy=%b dz=%b ovf=%b, want all 0",
               bus.q, bus.r, bus.rdy, bus.busy, bus.dz, bus.ovf);
    end
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.rdy !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: rdy=%b busy=%b, want 0 0", bus.rdy, bus.busy);
    end
  endtask

  task automatic test_directed();
    logic [NW-1:0] tn [6] = '{16'd100, 16'hFF9C, 16'd100, 16'd32767, 16'h8000, 16'd9};
    logic [W-1:0]  td [6] = '{8'd7, 8'd7, 8'hF9, 8'h80, 8'hFF, 8'd3};
    logic [NW+W+1:0] te [6] = '{{16'h000E, 8'h02, 2'b00}, {16'hFFF2, 8'hFE, 2'b00},
                                {16'hFFF2, 8'h02, 2'b00}, {16'hFF01, 8'h7F, 2'b00},
                                {16'h8000, 8'h00, 2'b01}, {16'h0003, 8'h00, 2'b00}};
    int lat; bit bok;
    for (int i = 0; i < 6; i++) begin
      run_op(tn[i], td[i], lat, bok);
      checks++;
      if ({bus.q, bus.r, bus.dz, bus.ovf} !== te[i]) begin
        errors++;
        $display("FAIL directed_%0d: got q=%h r=%h dz=%b ovf=%b, want %h", i,
                 bus.q, bus.r, bus.dz, bus.ovf, te[i]);
      end
      checks++;
      if (lat !== LAT) begin
        errors++;
        $display("FAIL directed_latency_%0d: got %0d edges, want %0d", i, lat, LAT);
      end
      checks++;
      if (!bok) begin
        errors++;
        $display("FAIL directed_busy_%0d: busy not high throughout run or overlaps rdy", i);
      end
    end
  endtask

  task automatic test_divzero();
    int lat; bit bok;
    run_op(16'd1234, 8'd0, lat, bok);
    checks++;
    if ({bus.q, bus.r, bus.dz, bus.ovf} !== {16'h0, 8'h0, 2'b10}) begin
      errors++;
      $display("FAIL divzero_result: got q=%h r=%h dz=%b ovf=%b, want 0 0 1 0",
               bus.q, bus.r, bus.dz, bus.ovf);
    end
    checks++;
    if (lat !== LAT_DZ) begin
      errors++;
      $display("FAIL divzero_latency: got %0d edges, want %0d", lat, LAT_DZ);
    end
    run_op(16'd9, 8'd3, lat, bok);
    checks++;
    if ({bus.q, bus.r, bus.dz, bus.ovf} !== {16'd3, 8'd0, 2'b00}) begin
      errors++;
      $display("FAIL divzero_recover: got q=%h r=%h dz=%b ovf=%b, want 0003 00 0 0",
               bus.q, bus.r, bus.dz, bus.ovf);
    end
  endtask

  task automatic test_hold();
    logic [NW+W+1:0] snap;
    snap = {bus.q, bus.r, bus.dz, bus.ovf};
    repeat (4) @(negedge clk);
    checks++;
    if (bus.rdy !== 1'b1 || {bus.q, bus.r, bus.dz, bus.ovf} !== model(16'd9, 8'd3)) begin
      errors++;
      $display("FAIL done_hold: got rdy=%b result=%h, want rdy=1 result=%h",
               bus.rdy, {bus.q, bus.r, bus.dz, bus.ovf}, snap);
    end
  endtask

  task automatic test_start_ignored();
    int lat;
    logic [NW-1:0] na; logic [W-1:0] da;
    na = 16'(-5000); da = 8'd37;
    @(negedge clk);
    bus.start = 1'b1; bus.n = na; bus.d = da;
    @(negedge clk);
    bus.start = 1'b0; lat = 0;
    while (!bus.rdy && lat < 40) begin
      if (lat == 5) begin
        bus.start = 1'b1; bus.n = 16'd777; bus.d = 8'hFD;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    checks++;
    if ({bus.q, bus.r, bus.dz, bus.ovf} !== model(na, da) || lat !== LAT) begin
      errors++;
      $display("FAIL start_ignored: got result=%h lat=%0d, want result=%h lat=%0d",
               {bus.q, bus.r, bus.dz, bus.ovf}, lat, model(na, da), LAT);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [NW+W+1:0] prev;
    logic [NW-1:0] nb; logic [W-1:0] db;
    nb = 16'd30000; db = 8'hF3;
    prev = {bus.q, bus.r, bus.dz, bus.ovf};
    @(negedge clk);
    bus.start = 1'b1; bus.n = nb; bus.d = db;
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.rdy !== 1'b0 || bus.busy !== 1'b1 || {bus.q, bus.r, bus.dz, bus.ovf} !== model(16'(-5000), 8'd37)) begin
      errors++;
      $display("FAIL b2b_accept: got rdy=%b busy=%b result=%h, want rdy=0 busy=1 result=%h",
               bus.rdy, bus.busy, {bus.q, bus.r, bus.dz, bus.ovf}, prev);
    end
    lat = 0;
    while (!bus.rdy && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if ({bus.q, bus.r, bus.dz, bus.ovf} !== model(nb, db) || lat !== LAT) begin
      errors++;
      $display("FAIL b2b_result: got result=%h lat=%0d, want result=%h lat=%0d",
               {bus.q, bus.r, bus.dz, bus.ovf}, lat, model(nb, db), LAT);
    end
  endtask

  task automatic test_reset_midrun();
    int lat; bit bok;
    @(negedge clk);
    bus.start = 1'b1; bus.n = 16'd12345; bus.d = 8'd11;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({bus.q, bus.r, bus.rdy, bus.busy, bus.dz, bus.ovf} !== '0) begin
      errors++;
      $display("FAIL reset_midrun: got q=%h r=%h rdy=%b busy=%b dz=%b ovf=%b, want all 0",
               bus.q, bus.r, bus.rdy, bus.busy, bus.dz, bus.ovf);
    end
    @(negedge clk);
    reset = 1'b0;
    run_op(16'hF00D, 8'd19, lat, bok);
    checks++;
    if ({bus.q, bus.r, bus.dz, bus.ovf} !== model(16'hF00D, 8'd19) || lat !== LAT || !bok) begin
      errors++;
      $display("FAIL reset_recover: got result=%h lat=%0d busy_ok=%b, want result=%h lat=%0d",
               {bus.q, bus.r, bus.dz, bus.ovf}, lat, bok, model(16'hF00D, 8'd19), LAT);
    end
  endtask

  task automatic test_random();
    int lat; bit bok;
    logic [NW-1:0] nn; logic [W-1:0] dd;
    for (int i = 0; i < 60; i++) begin
      nn = NW'($urandom);
      dd = W'($urandom);
      case ($urandom_range(0, 7))
        0: dd = '0;
        1: nn = 16'h8000;
        2: dd = 8'h80;
        3: dd = ($urandom_range(0, 1) != 0) ? 8'h01 : 8'hFF;
        default: ;
      endcase
      run_op(nn, dd, lat, bok);
      checks++;
      if ({bus.q, bus.r, bus.dz, bus.ovf} !== model(nn, dd)) begin
        errors++;
        $display("FAIL random_%0d n=%h d=%h: got q=%h r=%h dz=%b ovf=%b, want %h",
                 i, nn, dd, bus.q, bus.r, bus.dz, bus.ovf, model(nn, dd));
      end
      checks++;
      if (lat !== ((dd == '0) ? LAT_DZ : LAT) || !bok) begin
        errors++;
        $display("FAIL random_timing_%0d: got lat=%0d busy_ok=%b, want lat=%0d",
                 i, lat, bok, (dd == '0) ? LAT_DZ : LAT);
      end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.n = '0;
    bus.d = '0;
    test_reset();
    test_directed();
    test_divzero();
    test_hold();
    test_start_ignored();
    test_back_to_back();
    test_reset_midrun();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
